segre_store_buffer_mb: RTL and testbench
========================================

SEGRE_STORE_BUFFER_MB -- requirements
Module: segre_store_buffer_mb

Interface
REQ-001 Parameter NUM_ENTRIES, 4, buffer depth; SHALL be a power of two and >= 2.
REQ-002 Parameter ADDR_SIZE, 32, address width in bits.
REQ-003 Parameter WORD_SIZE, 32, data width in bits; SHALL be a multiple of 8, giving BYTES = WORD_SIZE/8.
REQ-004 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous and active-high.
REQ-006 st_req_i in 1 store request; st_addr_i in ADDR_SIZE store address (low log2(BYTES) bits ignored); st_data_i in WORD_SIZE store data; st_be_i in BYTES byte enables.
REQ-007 st_ack_o  out  1  store accepted this cycle (combinational).
REQ-008 ld_req_i in 1 load probe; ld_addr_i in ADDR_SIZE load address; ld_be_i in BYTES requested bytes.
REQ-009 ld_hit_o out 1 all requested bytes forwarded; ld_partial_o out 1 some but not all forwarded; ld_data_o out WORD_SIZE forwarded data.
REQ-010 cache_idle_i  in  1  cache can accept a drain this cycle (opportunistic drain).
REQ-011 flush_i  in  1  request a full drain.
REQ-012 drain_valid_o out 1; drain_ready_i in 1; drain_addr_o out ADDR_SIZE; drain_data_o out WORD_SIZE; drain_be_o out BYTES: drain channel to the cache.
REQ-013 full_o out 1; empty_o out 1; count_o out log2(NUM_ENTRIES)+1 occupancy; flushing_o out 1 flush in progress.

Function
REQ-014 The buffer SHALL be a circular FIFO with head (oldest) and tail (next free) pointers; the pointers SHALL wrap from NUM_ENTRIES-1 to 0.
REQ-015 Each entry SHALL hold valid, word address, data, and per-byte valid mask.
REQ-016 Word match SHALL compare addresses with the low log2(BYTES) bits ignored.
REQ-017 Store merge: when st_req_i is high, flushing_o is low, and st_addr_i matches a valid entry that is not the head entry under drain_valid_o, the store SHALL write the enabled bytes into that entry and OR st_be_i into its mask, with st_ack_o=1 and no allocation.
REQ-018 Store allocate: on no mergeable match and count_o < NUM_ENTRIES, the store SHALL be written at tail with mask st_be_i, tail SHALL advance, and st_ack_o SHALL be 1.
REQ-019 Store stall: when count_o == NUM_ENTRIES on a non-merge, or while flushing_o=1, st_ack_o SHALL be 0 and state SHALL remain unchanged; a drain handshake in the same cycle SHALL NOT unblock the store.
REQ-020 A store with st_be_i == 0 SHALL be acked and SHALL NOT change state.
REQ-021 drain_valid_o SHALL rise when empty_o=0 and (cache_idle_i or full_o or flushing_o) holds; once high, it and drain_addr/data/be_o (the head entry) SHALL stay stable until drain_ready_i is high.
REQ-022 Handshake: drain_valid_o & drain_ready_i SHALL invalidate head and advance it on that edge; drain_valid_o may stay high next cycle only if the drain condition still holds.
REQ-023 A simultaneous allocate and drain handshake SHALL leave count_o unchanged and move both pointers.
REQ-024 Load forwarding SHALL be combinational and SHALL NOT modify state; for each requested byte, data SHALL come from the youngest valid matching entry whose mask covers that byte.
REQ-025 Uncovered ld_data_o bytes SHALL be 0; ld_hit_o/ld_partial_o SHALL be 0 when ld_req_i=0.
REQ-026 Loads SHALL observe state before the same-cycle store.
REQ-027 A flush_i pulse SHALL set flushing_o on the next edge, which SHALL clear on the edge where the buffer becomes empty; flush_i when already empty SHALL be ignored.
REQ-028 full_o SHALL equal (count_o == NUM_ENTRIES) and empty_o SHALL equal (count_o == 0).

Reset
REQ-029 With rst_i high at an edge, all entries SHALL be invalidated, pointers zeroed, count_o=0, empty_o=1, full_o=0, flushing_o=0, drain_valid_o=0; a pending drain SHALL be discarded, with data outputs at 0.
REQ-030 While rst_i is high, st_ack_o, ld_hit_o, and ld_partial_o SHALL be 0.

Verification
REQ-031 Stores to 0x100 (be 0011, data 0x0000AAAA) then 0x100 (be 1100, 0xBBBB0000) -> one entry, count=1, load 0x100 be 1111 -> hit, 0xBBBBAAAA.
REQ-032 Fill 4 distinct addresses with cache_idle_i=0 -> full_o=1 and drain_valid_o=1; 5th store -> st_ack_o=0 until a handshake completes.
REQ-033 Hold drain_ready_i=0 for 3 cycles while a store to the head address arrives -> drain outputs stable, new entry allocated, load returns the newer data.
REQ-034 Load be 1111 to an address holding only be 0001 -> ld_partial_o=1, ld_data_o upper three bytes 0.
REQ-035 Pulse flush_i with 3 entries and drain_ready_i=1 -> 3 handshakes in order; stores stalled; flushing_o clears with empty_o=1.
REQ-036 Assert rst_i mid-drain with 2 entries -> next cycle count=0, drain_valid_o=0; pointer wrap verified by 2*NUM_ENTRIES stores and drains.

Source files
------------

// File: rtl/segre_store_buffer_mb_if.sv
// ---------------------------------------------------------------------------
// segre_store_buffer_mb_if
//
// Bundles every non-clock, non-reset signal of the store buffer into one
// interface. Signal names are written from the buffer's point of view:
// the _i suffix marks buffer inputs and the _o suffix marks buffer outputs.
//
//   store  : st_req_i, st_addr_i, st_data_i, st_be_i  -> st_ack_o
//   load   : ld_req_i, ld_addr_i, ld_be_i             -> ld_hit_o, ld_partial_o, ld_data_o
//   drain  : cache_idle_i, flush_i, drain_ready_i     -> drain_valid_o, drain_addr_o,
//                                                        drain_data_o, drain_be_o
//   status :                                          -> full_o, empty_o, count_o, flushing_o
//
// Modports:
//   slave  - the store buffer itself
//   master - the core/cache side driving requests and consuming responses
// ---------------------------------------------------------------------------
interface segre_store_buffer_mb_if #(
    parameter int ADDR_SIZE   = 32,
    parameter int WORD_SIZE   = 32,
    parameter int NUM_ENTRIES = 4
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

    logic                 st_req_i;
    logic [ADDR_SIZE-1:0] st_addr_i;
    logic [WORD_SIZE-1:0] st_data_i;
    logic [BYTES-1:0]     st_be_i;
    logic                 st_ack_o;

    logic                 ld_req_i;
    logic [ADDR_SIZE-1:0] ld_addr_i;
    logic [BYTES-1:0]     ld_be_i;
    logic                 ld_hit_o;
    logic                 ld_partial_o;
    logic [WORD_SIZE-1:0] ld_data_o;

    logic                 cache_idle_i;
    logic                 flush_i;
    logic                 drain_valid_o;
    logic                 drain_ready_i;
    logic [ADDR_SIZE-1:0] drain_addr_o;
    logic [WORD_SIZE-1:0] drain_data_o;
    logic [BYTES-1:0]     drain_be_o;

    logic                 full_o;
    logic                 empty_o;
    logic [CNT_W-1:0]     count_o;
    logic                 flushing_o;

    modport slave (
        input  st_req_i, st_addr_i, st_data_i, st_be_i,
        output st_ack_o,
        input  ld_req_i, ld_addr_i, ld_be_i,
        output ld_hit_o, ld_partial_o, ld_data_o,
        input  cache_idle_i, flush_i, drain_ready_i,
        output drain_valid_o, drain_addr_o, drain_data_o, drain_be_o,
        output full_o, empty_o, count_o, flushing_o
    );

    modport master (
        output st_req_i, st_addr_i, st_data_i, st_be_i,
        input  st_ack_o,
        output ld_req_i, ld_addr_i, ld_be_i,
        input  ld_hit_o, ld_partial_o, ld_data_o,
        output cache_idle_i, flush_i, drain_ready_i,
        input  drain_valid_o, drain_addr_o, drain_data_o, drain_be_o,
        input  full_o, empty_o, count_o, flushing_o
    );
endinterface

// File: rtl/segre_store_buffer_mb.sv
// ---------------------------------------------------------------------------
// segre_store_buffer_mb
//
// Merging store buffer sitting between the core and the data cache.
// Stores are coalesced per word into a circular FIFO of NUM_ENTRIES entries,
// loads are forwarded combinationally from buffered bytes (youngest wins),
// and entries drain oldest-first to the cache over a valid/ready channel,
// either opportunistically (cache idle), under pressure (full) or on a flush.
//
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_i  - synchronous active-high reset
//   sb     - segre_store_buffer_mb_if.slave carrying the store, load,
//            drain and status signals
// ---------------------------------------------------------------------------
module segre_store_buffer_mb #(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_SIZE   = 32,
    parameter int WORD_SIZE   = 32
) (
    input logic                    clk_i,
    input logic                    rst_i,
    segre_store_buffer_mb_if.slave sb
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_SIZE-1:0] WORD_MASK = ~(ADDR_SIZE'(BYTES - 1));

    if ((NUM_ENTRIES < 2) || ((NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0)) begin : g_bad_depth
        $error("segre_store_buffer_mb: NUM_ENTRIES must be a power of two >= 2");
    end
    if ((WORD_SIZE % 8) != 0) begin : g_bad_word
        $error("segre_store_buffer_mb: WORD_SIZE must be a multiple of 8");
    end

    typedef enum logic {
        DR_IDLE,   // nothing offered, or the previous offer was taken
        DR_OFFER   // head offered last cycle and not yet accepted
    } drain_state_e;

    // Entry storage. Only valid_q is reset; address/data/mask are always
    // rewritten on allocation before they can be observed.
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [ADDR_SIZE-1:0]   addr_q [NUM_ENTRIES];
    logic [WORD_SIZE-1:0]   data_q [NUM_ENTRIES];
    logic [BYTES-1:0]       mask_q [NUM_ENTRIES];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_n;
    logic             flushing_q, flushing_n;
    drain_state_e     dstate_q, dstate_n;

    logic             full, empty;
    logic             drain_cond, drain_valid, hs;
    logic [ADDR_SIZE-1:0] st_word, ld_word;
    logic             merge_hit;
    logic [PTR_W-1:0] merge_idx;
    logic             store_open, st_nonzero, do_merge, do_alloc, st_ack;
    logic [WORD_SIZE-1:0] fwd_data;
    logic [BYTES-1:0]     fwd_cov;
    logic             ld_open;

    function automatic logic [WORD_SIZE-1:0] be_to_bits(input logic [BYTES-1:0] be);
        logic [WORD_SIZE-1:0] r;
        r = '0;
        for (int b = 0; b < BYTES; b++) begin
            r[b*8 +: 8] = {8{be[b]}};
        end
        return r;
    endfunction

    assign full  = (count_q == CNT_W'(NUM_ENTRIES));
    assign empty = (count_q == '0);

    assign drain_cond = !empty && (sb.cache_idle_i || full || flushing_q);

    // ---------------- drain FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dstate_q <= DR_IDLE;
        end else begin
            dstate_q <= dstate_n;
        end
    end

    // ---------------- drain FSM: next state ----------------
    // An offer that is not taken keeps the channel committed, so valid and
    // the head fields stay put even if the drain condition goes away.
    always_comb begin
        dstate_n = DR_IDLE;
        if (drain_valid && !sb.drain_ready_i) begin
            dstate_n = DR_OFFER;
        end
    end

    // ---------------- drain FSM: outputs ----------------
    always_comb begin
        drain_valid = (dstate_q == DR_OFFER) || drain_cond;
        sb.drain_valid_o = drain_valid;
        sb.drain_addr_o  = '0;
        sb.drain_data_o  = '0;
        sb.drain_be_o    = '0;
        if (drain_valid) begin
            sb.drain_addr_o = addr_q[head_q];
            sb.drain_data_o = data_q[head_q];
            sb.drain_be_o   = mask_q[head_q];
        end
    end

    assign hs = drain_valid && sb.drain_ready_i;

    // Merge target search: walk oldest to youngest so the last match wins,
    // skipping the head while it is being offered to the cache.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        st_word   = sb.st_addr_i & WORD_MASK;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            logic [PTR_W-1:0] idx;
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == st_word) &&
                !(drain_valid && (idx == head_q))) begin
                merge_hit = 1'b1;
                merge_idx = idx;
            end
        end
    end

    // A full buffer only takes merges; a drain in the same cycle does not
    // free a slot for the store because the decision uses pre-edge count.
    assign store_open = sb.st_req_i && !flushing_q && !rst_i;
    assign st_nonzero = |sb.st_be_i;
    assign do_merge   = store_open && st_nonzero && merge_hit;
    assign do_alloc   = store_open && st_nonzero && !merge_hit && !full;
    assign st_ack     = store_open && (!st_nonzero || merge_hit || !full);
    assign sb.st_ack_o = st_ack;

    always_comb begin
        count_n = count_q;
        if (do_alloc && !hs) begin
            count_n = count_q + CNT_W'(1);
        end else if (!do_alloc && hs) begin
            count_n = count_q - CNT_W'(1);
        end
    end

    // flush_i on an empty buffer never sets the flag; the flag drops on the
    // edge that leaves the buffer empty.
    assign flushing_n = (flushing_q || (sb.flush_i && !empty)) && (count_n != '0);

    // Control state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            flushing_q <= 1'b0;
        end else begin
            // tail == head only when empty (no handshake) or full (no
            // allocation), so these two valid_q writes never collide.
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (hs) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            count_q    <= count_n;
            flushing_q <= flushing_n;
        end
    end

    // Entry payload
    always_ff @(posedge clk_i) begin
        if (do_alloc) begin
            addr_q[tail_q] <= st_word;
            data_q[tail_q] <= sb.st_data_i & be_to_bits(sb.st_be_i);
            mask_q[tail_q] <= sb.st_be_i;
        end else if (do_merge) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sb.st_be_i[b]) begin
                    data_q[merge_idx][b*8 +: 8] <= sb.st_data_i[b*8 +: 8];
                end
            end
            mask_q[merge_idx] <= mask_q[merge_idx] | sb.st_be_i;
        end
    end

    // Load forwarding from pre-edge state; younger entries overwrite older
    // ones byte by byte.
    always_comb begin
        fwd_data = '0;
        fwd_cov  = '0;
        ld_word  = sb.ld_addr_i & WORD_MASK;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            logic [PTR_W-1:0] idx;
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_word)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (mask_q[idx][b] && sb.ld_be_i[b]) begin
                        fwd_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
                        fwd_cov[b]         = 1'b1;
                    end
                end
            end
        end
    end

    assign ld_open         = sb.ld_req_i && !rst_i;
    assign sb.ld_hit_o     = ld_open && (sb.ld_be_i != '0) && (fwd_cov == sb.ld_be_i);
    assign sb.ld_partial_o = ld_open && (fwd_cov != '0) && (fwd_cov != sb.ld_be_i);
    assign sb.ld_data_o    = ld_open ? fwd_data : '0;

    assign sb.full_o     = full;
    assign sb.empty_o    = empty;
    assign sb.count_o    = count_q;
    assign sb.flushing_o = flushing_q;

endmodule

// File: tb/tb_segre_store_buffer_mb.sv
// ---------------------------------------------------------------------------
// tb_segre_store_buffer_mb
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model (oldest entry at index 0) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_segre_store_buffer_mb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int WW = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    segre_store_buffer_mb_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .NUM_ENTRIES(N)) bus ();

    segre_store_buffer_mb #(.NUM_ENTRIES(N), .ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (bus)
    );

    ent_t mq[$];
    bit   m_flush;
    bit   m_pend;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] be_bits(input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{be[b]}};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.st_req_i  = 1'b0;
        bus.st_addr_i = '0;
        bus.st_data_i = '0;
        bus.st_be_i   = '0;
        bus.ld_req_i  = 1'b0;
        bus.ld_addr_i = '0;
        bus.ld_be_i   = '0;
        bus.flush_i   = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.st_req_i  = 1'b1;
        bus.st_addr_i = a;
        bus.st_data_i = d;
        bus.st_be_i   = be;
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] be);
        bus.ld_req_i  = 1'b1;
        bus.ld_addr_i = a;
        bus.ld_be_i   = be;
    endtask

    // Check all outputs against the model for the current inputs, advance
    // the model, and step one clock.
    task automatic cycle();
        int size, mi;
        bit full, e_dv, e_ack, alloc, hs;
        logic [31:0] sw, lw, e_ld;
        logic [3:0] cov;
        ent_t e;
        #2;
        if (rst) begin
            chk("rst_st_ack", bus.st_ack_o, 0);
            chk("rst_ld_hit", bus.ld_hit_o, 0);
            chk("rst_ld_partial", bus.ld_partial_o, 0);
            mq.delete();
            m_flush = 0;
            m_pend  = 0;
            @(posedge clk);
            #1;
            return;
        end
        size = mq.size();
        full = (size == N);
        e_dv = m_pend || ((size > 0) && (bus.cache_idle_i || full || m_flush));

        sw = bus.st_addr_i & ~32'h3;
        e_ack = 0; alloc = 0; mi = -1;
        if (bus.st_req_i && !m_flush) begin
            if (bus.st_be_i == 4'h0) e_ack = 1;
            else begin
                for (int i = size - 1; i >= 0; i--) begin
                    if (mq[i].addr == sw && !(e_dv && i == 0)) begin mi = i; break; end
                end
                if (mi >= 0) e_ack = 1;
                else if (size < N) begin e_ack = 1; alloc = 1; end
            end
        end

        lw = bus.ld_addr_i & ~32'h3;
        e_ld = '0; cov = '0;
        if (bus.ld_req_i) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ld_be_i[b]) begin
                    for (int i = size - 1; i >= 0; i--) begin
                        if (mq[i].addr == lw && mq[i].be[b]) begin
                            e_ld[b*8 +: 8] = mq[i].data[b*8 +: 8];
                            cov[b] = 1'b1;
                            break;
                        end
                    end
                end
            end
        end

        chk("st_ack", bus.st_ack_o, e_ack);
        chk("ld_hit", bus.ld_hit_o, bus.ld_req_i && cov == bus.ld_be_i && bus.ld_be_i != 0);
        chk("ld_partial", bus.ld_partial_o, bus.ld_req_i && cov != 0 && cov != bus.ld_be_i);
        if (bus.ld_req_i) chk("ld_data", bus.ld_data_o, e_ld);
        chk("drain_valid", bus.drain_valid_o, e_dv);
        chk("drain_addr", bus.drain_addr_o, e_dv ? mq[0].addr : 32'h0);
        chk("drain_data", bus.drain_data_o, e_dv ? mq[0].data : 32'h0);
        chk("drain_be", bus.drain_be_o, e_dv ? mq[0].be : 4'h0);
        chk("full", bus.full_o, full);
        chk("empty", bus.empty_o, size == 0);
        chk("count", bus.count_o, size);
        chk("flushing", bus.flushing_o, m_flush);

        hs = e_dv && bus.drain_ready_i;
        if (mi >= 0) begin
            e = mq[mi];
            for (int b = 0; b < 4; b++)
                if (bus.st_be_i[b]) e.data[b*8 +: 8] = bus.st_data_i[b*8 +: 8];
            e.be = e.be | bus.st_be_i;
            mq[mi] = e;
        end
        if (alloc) begin
            e.addr = sw;
            e.data = bus.st_data_i & be_bits(bus.st_be_i);
            e.be   = bus.st_be_i;
            mq.push_back(e);
        end
        if (hs) void'(mq.pop_front());
        m_flush = (m_flush || (bus.flush_i && size > 0)) && (mq.size() != 0);
        m_pend  = e_dv && !bus.drain_ready_i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        bus.cache_idle_i  = 1'b0;
        bus.drain_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        st(32'h100, 32'h1, 4'hF);
        ld(32'h100, 4'hF);
        cycle();
        cycle();
        rst = 1'b0;
        quiet();
        #1;
        chk("reset_count", bus.count_o, 0);
        chk("reset_empty", bus.empty_o, 1);
        chk("reset_full", bus.full_o, 0);
        chk("reset_drain_valid", bus.drain_valid_o, 0);
        cycle();

        // Merge two halves of one word
        st(32'h100, 32'h0000AAAA, 4'b0011); cycle();
        st(32'h100, 32'hBBBB0000, 4'b1100); cycle();
        quiet(); ld(32'h100, 4'hF); #1;
        chk("merge_count", bus.count_o, 1);
        chk("merge_hit", bus.ld_hit_o, 1);
        chk("merge_data", bus.ld_data_o, 32'hBBBBAAAA);
        cycle();

        // Partial forward, low address bits ignored
        quiet(); st(32'h203, 32'h12345678, 4'b0001); cycle();
        quiet(); ld(32'h200, 4'hF); #1;
        chk("partial_flag", bus.ld_partial_o, 1);
        chk("partial_hit", bus.ld_hit_o, 0);
        chk("partial_data", bus.ld_data_o, 32'h00000078);
        cycle();

        // Fill to full, fifth store stalls until a handshake completes
        quiet(); st(32'h300, 32'h33333333, 4'hF); cycle();
        st(32'h400, 32'h44444444, 4'hF); cycle();
        st(32'h500, 32'h55555555, 4'hF); #1;
        chk("full_flag", bus.full_o, 1);
        chk("full_drain_valid", bus.drain_valid_o, 1);
        chk("full_stall_ack", bus.st_ack_o, 0);
        cycle();
        #1; chk("full_stall_ack2", bus.st_ack_o, 0); cycle();
        bus.drain_ready_i = 1'b1; #1;
        chk("stall_during_hs", bus.st_ack_o, 0);
        chk("hs_addr", bus.drain_addr_o, 32'h100);
        cycle();
        bus.drain_ready_i = 1'b0; #1;
        chk("after_hs_count", bus.count_o, 3);
        chk("after_hs_ack", bus.st_ack_o, 1);
        cycle();
        quiet();

        // Store to the head while it is being offered allocates a new entry
        bus.drain_ready_i = 1'b1; #1;
        chk("drain_200", bus.drain_addr_o, 32'h200);
        cycle();
        bus.drain_ready_i = 1'b0; bus.cache_idle_i = 1'b1;
        st(32'h300, 32'hCAFEF00D, 4'hF); #1;
        chk("head_lock_addr", bus.drain_addr_o, 32'h300);
        chk("head_lock_ack", bus.st_ack_o, 1);
        cycle();
        quiet(); ld(32'h300, 4'hF); #1;
        chk("newer_count", bus.count_o, 4);
        chk("newer_hit", bus.ld_hit_o, 1);
        chk("newer_data", bus.ld_data_o, 32'hCAFEF00D);
        chk("stable_data1", bus.drain_data_o, 32'h33333333);
        cycle();
        #1;
        chk("stable_data2", bus.drain_data_o, 32'h33333333);
        chk("stable_addr2", bus.drain_addr_o, 32'h300);
        cycle();
        bus.drain_ready_i = 1'b1; #1;
        chk("stable_data3", bus.drain_data_o, 32'h33333333);
        cycle();
        bus.cache_idle_i = 1'b0;
        quiet();

        // Flush three entries with stores stalled
        bus.flush_i = 1'b1; #1;
        chk("flush_pre_dv", bus.drain_valid_o, 0);
        cycle();
        bus.flush_i = 1'b0; st(32'h600, 32'h66666666, 4'hF); #1;
        chk("flushing_set", bus.flushing_o, 1);
        chk("flush_addr0", bus.drain_addr_o, 32'h400);
        chk("flush_stall", bus.st_ack_o, 0);
        cycle();
        #1; chk("flush_addr1", bus.drain_addr_o, 32'h500); cycle();
        #1;
        chk("flush_addr2", bus.drain_addr_o, 32'h300);
        chk("flush_data2", bus.drain_data_o, 32'hCAFEF00D);
        cycle();
        quiet(); #1;
        chk("flush_done", bus.flushing_o, 0);
        chk("flush_empty", bus.empty_o, 1);
        cycle();
        bus.flush_i = 1'b1; cycle();
        bus.flush_i = 1'b0; #1;
        chk("flush_empty_ignored", bus.flushing_o, 0);
        cycle();

        // Reset in the middle of a pending drain
        bus.drain_ready_i = 1'b0; bus.cache_idle_i = 1'b1;
        st(32'h700, 32'h77777777, 4'hF); cycle();
        st(32'h704, 32'h78787878, 4'hF); cycle();
        quiet(); #1;
        chk("pre_rst_count", bus.count_o, 2);
        chk("pre_rst_dv", bus.drain_valid_o, 1);
        rst = 1'b1; cycle();
        rst = 1'b0; #1;
        chk("mid_rst_count", bus.count_o, 0);
        chk("mid_rst_dv", bus.drain_valid_o, 0);
        chk("mid_rst_ddata", bus.drain_data_o, 0);
        cycle();

        // Pointer wrap: 2*N store/drain pairs
        bus.drain_ready_i = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            st(32'h800 + 32'(k) * 16, $urandom, 4'hF);
            cycle();
        end
        quiet(); cycle(); cycle();
        #1; chk("wrap_empty", bus.empty_o, 1);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            quiet();
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 1) == 1)
                st(32'h100 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3), $urandom,
                   4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1)
                ld(32'h100 + 4 * $urandom_range(0, 5), 4'($urandom_range(1, 15)));
            bus.cache_idle_i  = ($urandom_range(0, 2) == 0);
            bus.drain_ready_i = ($urandom_range(0, 1) == 1);
            bus.flush_i       = ($urandom_range(0, 24) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
